// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits, line refill over a
// beat-handshake memory port, and whole-cache invalidate for fence.i.
module icache_dm #(
    parameter int unsigned ADR_WIDTH  = 32,
    parameter int unsigned SET_NUM    = 64,
    parameter int unsigned LINE_BEATS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_fetch_valid,
    output logic                 o_fetch_ready,
    input  logic [1:0]           i_fetch_reqtyp,
    input  logic [1:0]           i_fetch_size,
    input  logic [ADR_WIDTH-1:0] i_fetch_addr,
    input  logic [63:0]          i_fetch_wdata,
    output logic [63:0]          o_fetch_rdata,
    input  logic                 i_fence_i,
    output logic                 o_mem_valid,
    output logic [ADR_WIDTH-1:0] o_mem_addr,
    input  logic                 i_mem_ready,
    input  logic [63:0]          i_mem_rdata,
    output logic [31:0]          o_hit_cnt,
    output logic [31:0]          o_miss_cnt
);
    localparam int unsigned OffW  = $clog2(8 * LINE_BEATS);
    localparam int unsigned IdxW  = $clog2(SET_NUM);
    localparam int unsigned BeatW = $clog2(LINE_BEATS);
    localparam int unsigned TagW  = ADR_WIDTH - OffW - IdxW;
    localparam int unsigned LineW = ADR_WIDTH - OffW;

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    state_e             state_q, state_d;
    logic [SET_NUM-1:0] valid_q, valid_d;
    logic [LineW-1:0]   line_q, line_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic               pend_q, pend_d;
    logic [31:0]        hit_cnt_q, hit_cnt_d;
    logic [31:0]        miss_cnt_q, miss_cnt_d;

    logic [TagW-1:0] tag_q  [SET_NUM];
    logic [63:0]     data_q [SET_NUM][LINE_BEATS];

    logic [TagW-1:0]  fetch_tag;
    logic [IdxW-1:0]  fetch_idx;
    logic [BeatW-1:0] fetch_beat;
    logic [IdxW-1:0]  refill_idx;
    logic [TagW-1:0]  refill_tag;
    logic [63:0]      hit_beat;
    logic             hit;
    logic             last_beat;
    logic             refill_we;
    logic             unused_inputs;

    // Request type, size, write data and byte offset are ignored: every fetch is a 32-bit read.
    assign unused_inputs = ^{i_fetch_reqtyp, i_fetch_size, i_fetch_wdata, i_fetch_addr[1:0]};

    assign fetch_tag  = i_fetch_addr[ADR_WIDTH-1 -: TagW];
    assign fetch_idx  = i_fetch_addr[OffW +: IdxW];
    assign fetch_beat = i_fetch_addr[3 +: BeatW];
    assign refill_idx = line_q[IdxW-1:0];
    assign refill_tag = line_q[LineW-1 -: TagW];
    assign hit_beat   = data_q[fetch_idx][fetch_beat];

    assign hit = (state_q == StIdle) && i_fetch_valid && !i_fence_i &&
                 valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign last_beat = (beat_q == BeatW'(LINE_BEATS - 1));
    assign refill_we = (state_q == StRefill) && i_mem_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            line_q     <= '0;
            beat_q     <= '0;
            pend_q     <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            line_q     <= line_d;
            beat_q     <= beat_d;
            pend_q     <= pend_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (refill_we) begin
            data_q[refill_idx][beat_q] <= i_mem_rdata;
            if (last_beat) begin
                tag_q[refill_idx] <= refill_tag;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        line_d     = line_q;
        beat_d     = beat_q;
        pend_d     = pend_q;
        hit_cnt_d  = hit ? hit_cnt_q + 32'd1 : hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_fence_i) begin
                    valid_d = '0;
                end else if (i_fetch_valid && !hit) begin
                    line_d     = i_fetch_addr[ADR_WIDTH-1:OffW];
                    beat_d     = '0;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d    = StRefill;
                end
            end
            StRefill: begin
                if (i_fence_i) begin
                    pend_d = 1'b1;
                end
                if (i_mem_ready) begin
                    beat_d = beat_q + BeatW'(1);
                    if (last_beat) begin
                        state_d = StIdle;
                        pend_d  = 1'b0;
                        // A fence seen at any point during the refill also kills the new line.
                        if (pend_q || i_fence_i) begin
                            valid_d = '0;
                        end else begin
                            valid_d[refill_idx] = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_fetch_ready = hit;
        o_fetch_rdata = '0;
        if (hit) begin
            o_fetch_rdata = {32'h0, i_fetch_addr[2] ? hit_beat[63:32] : hit_beat[31:0]};
        end
        o_mem_valid = (state_q == StRefill);
        o_mem_addr  = o_mem_valid ? {line_q, beat_q, 3'b000} : '0;
        o_hit_cnt   = hit_cnt_q;
        o_miss_cnt  = miss_cnt_q;
    end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit run, conflict, flush, fence and reset
// mid-refill against a stallable memory model.
module tb_icache_dm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_addr = 32'h0;
    logic [63:0] fetch_rdata;
    logic        fence = 1'b0;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int stall = 0;
    int wait_cnt;
    int lat;

    always #5 clk = ~clk;

    icache_dm #(.ADR_WIDTH(32), .SET_NUM(64), .LINE_BEATS(2)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_fetch_valid  (fetch_valid),
        .o_fetch_ready  (fetch_ready),
        .i_fetch_reqtyp (2'b00),
        .i_fetch_size   (2'b10),
        .i_fetch_addr   (fetch_addr),
        .i_fetch_wdata  (64'h0),
        .o_fetch_rdata  (fetch_rdata),
        .i_fence_i      (fence),
        .o_mem_valid    (mem_valid),
        .o_mem_addr     (mem_addr),
        .i_mem_ready    (mem_ready),
        .i_mem_rdata    (mem_rdata),
        .o_hit_cnt      (hit_cnt),
        .o_miss_cnt     (miss_cnt)
    );

    function automatic logic [63:0] mem_data(input logic [31:0] a);
        case (a)
            32'h8000_0000: return 64'h00000013_00100093;
            32'h8000_0008: return 64'h00000297_00000517;
            default:       return {~a, a ^ 32'h5A5A_0000};
        endcase
    endfunction

    function automatic logic [63:0] exp_rdata(input logic [31:0] a);
        logic [63:0] b;
        b = mem_data({a[31:3], 3'b000});
        return a[2] ? {32'h0, b[63:32]} : {32'h0, b[31:0]};
    endfunction

    // Memory answers after `stall` wait cycles per beat.
    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mem_ready = mem_valid && (wait_cnt >= stall);
    assign mem_rdata = mem_data(mem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        while (!fetch_ready && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_lat, input string tag);
        int n;
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        #1;
        wait_ready(100, n);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_rdata"}, fetch_rdata, exp_rdata(a));
    endtask

    task automatic idle();
        @(negedge clk);
        fetch_valid = 1'b0;
        fence       = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 64'(fetch_ready), 64'd0);
        check("rst_rdata", fetch_rdata, 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, cycle by cycle
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8000_0000;
        #1;
        check("cold_c0_ready", 64'(fetch_ready), 64'd0);
        @(negedge clk);
        #1;
        check("cold_c1_mem_valid", 64'(mem_valid), 64'd1);
        check("cold_c1_mem_addr", 64'(mem_addr), 64'h8000_0000);
        @(negedge clk);
        #1;
        check("cold_c2_mem_addr", 64'(mem_addr), 64'h8000_0008);
        @(negedge clk);
        #1;
        check("cold_c3_ready", 64'(fetch_ready), 64'd1);
        check("cold_c3_rdata", fetch_rdata, 64'h0010_0093);
        check("cold_miss_cnt", 64'(miss_cnt), 64'd1);

        // Back-to-back hits
        fetch(32'h8000_0004, 0, "hit4");
        check("hit4_word", fetch_rdata, 64'h0000_0013);
        fetch(32'h8000_0008, 0, "hit8");
        check("hit8_word", fetch_rdata, 64'h0000_0517);
        fetch(32'h8000_000C, 0, "hitC");
        check("hitC_word", fetch_rdata, 64'h0000_0297);
        idle();
        check("hit_run_cnt", 64'(hit_cnt), 64'd4);

        // Conflict in set 0
        fetch(32'h8000_0400, 3, "conf_400");
        fetch(32'h8000_0000, 3, "conf_000");
        idle();
        check("conf_miss_cnt", 64'(miss_cnt), 64'd3);

        // Fence with valid high on a warm line
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8000_0000;
        fence       = 1'b1;
        #1;
        check("fence_ready", 64'(fetch_ready), 64'd0);
        check("fence_mem_valid", 64'(mem_valid), 64'd0);
        @(negedge clk);
        fence = 1'b0;
        #1;
        check("fence_next_ready", 64'(fetch_ready), 64'd0);
        wait_ready(100, lat);
        check("fence_refetch_lat", 64'(lat), 64'd3);
        check("fence_refetch_rdata", fetch_rdata, 64'h0010_0093);
        idle();
        check("fence_miss_cnt", 64'(miss_cnt), 64'd4);
        check("fence_hit_cnt", 64'(hit_cnt), 64'd7);

        // Address change mid-refill with a stalling memory
        @(negedge clk);
        fence = 1'b1;
        @(negedge clk);
        fence = 1'b0;
        stall = 5;
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8000_0000;
        #1;
        check("flush_c0_ready", 64'(fetch_ready), 64'd0);
        @(negedge clk);
        #1;
        check("flush_c1_mem_addr", 64'(mem_addr), 64'h8000_0000);
        @(negedge clk);
        fetch_addr = 32'h8000_0010;
        #1;
        check("flush_c2_mem_valid", 64'(mem_valid), 64'd1);
        check("flush_c2_mem_addr", 64'(mem_addr), 64'h8000_0000);
        wait_ready(100, lat);
        check("flush_lat", 64'(lat), 64'd24);
        check("flush_rdata", fetch_rdata, exp_rdata(32'h8000_0010));
        idle();
        check("flush_miss_cnt", 64'(miss_cnt), 64'd6);
        stall = 0;
        fetch(32'h8000_0000, 0, "flush_old_hit");
        idle();
        check("flush_hit_cnt", 64'(hit_cnt), 64'd9);

        // Fence while refilling: the completed line is invalidated too
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8000_0040;
        #1;
        @(negedge clk);
        fetch_valid = 1'b0;
        fence       = 1'b1;
        #1;
        check("fref_mem_valid", 64'(mem_valid), 64'd1);
        @(negedge clk);
        fence = 1'b0;
        #1;
        @(negedge clk);
        #1;
        check("fref_done", 64'(mem_valid), 64'd0);
        fetch(32'h8000_0040, 3, "fref_line");
        fetch(32'h8000_0000, 3, "fref_other");
        idle();
        check("fref_miss_cnt", 64'(miss_cnt), 64'd9);
        check("fref_hit_cnt", 64'(hit_cnt), 64'd11);

        // Reset in the middle of a refill
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h8000_0050;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_mem_valid", 64'(mem_valid), 64'd0);
        check("mrst_mem_addr", 64'(mem_addr), 64'd0);
        check("mrst_ready", 64'(fetch_ready), 64'd0);
        check("mrst_hit_cnt", 64'(hit_cnt), 64'd0);
        check("mrst_miss_cnt", 64'(miss_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_c0_ready", 64'(fetch_ready), 64'd0);
        wait_ready(100, lat);
        check("mrst_refetch_lat", 64'(lat), 64'd3);
        check("mrst_refetch_rdata", fetch_rdata, exp_rdata(32'h8000_0050));

        // Top set and set 5 coexist
        fetch(32'h8000_03F0, 3, "wrap_top");
        fetch(32'h8000_0050, 0, "wrap_set5");
        fetch(32'h8000_03F4, 0, "wrap_top_hi");
        idle();
        check("end_hit_cnt", 64'(hit_cnt), 64'd4);
        check("end_miss_cnt", 64'(miss_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
